axis_uart_tx: RTL and testbench
===============================

AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, the clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port S_AXIS_TVALID  input  1  upstream word valid.
REQ-005 SHALL have port S_AXIS_TREADY  output  1  block can accept a word this cycle.
REQ-006 SHALL have port S_AXIS_TDATA  input  32  word to transmit, byte 0 = bits 7:0.
REQ-007 SHALL have port S_AXIS_TLAST  input  1  word ends a packet.
REQ-008 SHALL have port uart_txd  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while shifter is not IDLE or holding buffer is full.
REQ-010 SHALL have port last_done  output  1  one-cycle pulse when final stop bit of a TLAST word completes.

Function
REQ-011 SHALL accept a word on an edge where S_AXIS_TVALID and S_AXIS_TREADY are both high, storing TDATA and TLAST in a one-word holding buffer.
REQ-012 SHALL drive S_AXIS_TREADY high iff the holding buffer is empty and the ready register is set (REQ-025); accept and drain never occur on the same edge.
REQ-013 SHALL implement a shifter FSM with states IDLE, START, DATA, PARITY (only with REQ-027 macro), STOP.
REQ-014 SHALL, on an edge in IDLE with buffer full, move buffer into shifter, empty buffer, set byte index 0, enter START; start bit appears on uart_txd one cycle after the accept edge at earliest.
REQ-015 SHALL hold each bit on uart_txd for exactly CLKS_PER_BIT cycles using a baud counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-016 SHALL transmit per byte: start bit 0, 8 data bits LSB first, [parity], stop bit 1.
REQ-017 SHALL send bytes 0,1,2,3 in order; after byte 3 STOP, go to START of next word if buffer full (no idle gap), else IDLE.
REQ-018 SHALL take 40*CLKS_PER_BIT cycles per word (44*CLKS_PER_BIT with parity).
REQ-019 SHALL pulse last_done for exactly one cycle on the edge byte 3 STOP completes, only if that word had TLAST=1.
REQ-020 SHALL drive uart_txd from a register (no combinational glitches).
REQ-021 SHALL NOT check AXI stability of TDATA/TLAST while TVALID high and TREADY low; that is upstream's obligation.

Reset
REQ-022 SHALL, on an edge with reset_n low, set FSM IDLE, buffer empty, all counters 0.
REQ-023 SHALL reset outputs: uart_txd 1, busy 0, last_done 0, S_AXIS_TREADY 0.
REQ-024 SHALL, when reset asserts mid-transfer, abort: uart_txd high on that edge, partial word and buffered word discarded, no last_done.
REQ-025 SHALL set the ready register on the first edge with reset_n high, so S_AXIS_TREADY rises one cycle after reset release.

Configuration
REQ-026 SHALL, without AXIS_UART_PARITY_EN defined, transmit 8N1 and never enter PARITY.
REQ-027 SHALL, with AXIS_UART_PARITY_EN defined, insert PARITY between DATA and STOP carrying even parity (XOR of 8 data bits), CLKS_PER_BIT long.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL cover: word 0x44332211, TLAST=0 -> txd frames 0x11,0x22,0x33,0x44 LSB first, 160 cycles, busy high throughout, last_done never pulses.
REQ-029 SHALL cover: two words TVALID held continuously -> second accepted the edge after first loads shifter, 320 cycles contiguous, no idle high bit between words.
REQ-030 SHALL cover: word 0xA5A5A5A5 TLAST=1 -> last_done high exactly one cycle, coincident with end of fourth stop bit.
REQ-031 SHALL cover: third word offered while buffer full -> TREADY low, no accept until shifter loads word two; all three words transmitted in order.
REQ-032 SHALL cover: reset_n low during byte 2 DATA -> uart_txd 1, busy 0, TREADY 0 next cycle, TREADY 1 one cycle after release, no last_done.
REQ-033 SHALL cover with AXIS_UART_PARITY_EN: word 0x00000007 -> parity bit 1 in byte 0, 0 in bytes 1-3, 176 cycles total.

Source files
------------

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: serializes 32-bit AXI-Stream words as four UART bytes, byte 0 first.
// Define AXIS_UART_PARITY_EN for 8E1 framing; the default build is 8N1.
module axis_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        uart_txd,
    output logic        busy,
    output logic        last_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef AXIS_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [1:0]  r_byte;
    logic [1:0]  w_byte_nxt;
    logic [31:0] r_word;
    logic [31:0] w_word_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic [31:0] r_buf_data;
    logic        r_buf_last;
    logic        r_buf_full;
    logic        r_ready;
    logic        r_txd;
    logic        r_last_done;
    logic        w_accept;
    logic        w_load;
    logic        w_bit_end;
    logic        w_done;
    logic        w_txd_nxt;
`ifdef AXIS_UART_PARITY_EN
    logic [7:0]  w_cur_byte;
`endif

    assign S_AXIS_TREADY = r_ready & ~r_buf_full;
    assign w_accept      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_bit_end     = (r_baud == 16'(CLKS_PER_BIT - 1));
    assign uart_txd      = r_txd;
    assign busy          = (r_state != S_IDLE) | r_buf_full;
    assign last_done     = r_last_done;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_load      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_buf_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
`ifdef AXIS_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
`ifdef AXIS_UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte == 2'd3) begin
                        w_done = r_last;
                        // Chain straight into the next word to keep the line busy
                        if (r_buf_full) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_byte_nxt  = r_byte + 2'd1;
                        w_state_nxt = S_START;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_byte_nxt = 2'd0;
            w_bit_nxt  = 3'd0;
        end
    end

    always_comb begin
        w_word_nxt = w_load ? r_buf_data : r_word;
        w_last_nxt = w_load ? r_buf_last : r_last;
`ifdef AXIS_UART_PARITY_EN
        w_cur_byte = w_word_nxt[{w_byte_nxt, 3'b000} +: 8];
`endif
        w_txd_nxt = 1'b1;
        unique case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_word_nxt[{w_byte_nxt, w_bit_nxt}];
`ifdef AXIS_UART_PARITY_EN
            S_PARITY: w_txd_nxt = ^w_cur_byte;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_txd       <= 1'b1;
            r_last_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit       <= w_bit_nxt;
            r_byte      <= w_byte_nxt;
            r_word      <= w_word_nxt;
            r_last      <= w_last_nxt;
            r_txd       <= w_txd_nxt;
            r_last_done <= w_done;
            if (w_load || r_state == S_IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready    <= 1'b0;
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
            r_buf_last <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_data <= S_AXIS_TDATA;
                r_buf_last <= S_AXIS_TLAST;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: scoreboard bench; a UART receiver monitor checks bytes,
// framing, word end timing and last_done against queued expectations.
module tb_axis_uart_tx;
    localparam int C = 4;
`ifdef AXIS_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int WC = 4 * NB * C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [31:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        txd;
    logic        busy;
    logic        ld;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp_b[$];
    bit         exp_l[$];
    int         exp_e[$];

    bit         in_frame = 0;
    bit         pend = 0;
    bit         pend_v = 0;
    int         pend_e = 0;
    int         cnt = 0;
    int         nbytes = 0;
    logic [7:0] rx = '0;

    axis_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .S_AXIS_TDATA(tdata),
        .S_AXIS_TLAST(tlast),
        .uart_txd(txd),
        .busy(busy),
        .last_done(ld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, expv, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame = 0;
                pend = 0;
                nbytes = 0;
                exp_b.delete();
                exp_l.delete();
                exp_e.delete();
            end else begin
                if (pend || ld) begin
                    chk("last_done", 32'(ld), 32'(pend && pend_v));
                    if (pend) chk("word_end_cycle", cyc, pend_e);
                    pend = 0;
                end
                if (in_frame) begin
                    cnt++;
                    if (cnt % C == C / 2) begin
                        if (cnt / C >= 1 && cnt / C <= 8) rx[cnt / C - 1] = txd;
`ifdef AXIS_UART_PARITY_EN
                        if (cnt / C == 9 && exp_b.size() != 0)
                            chk("parity_bit", 32'(txd), 32'(^exp_b[0]));
`endif
                        if (cnt / C == NB - 1) begin
                            chk("stop_bit", 32'(txd), 32'd1);
                            if (exp_b.size() == 0) begin
                                chk("unexpected_byte", 32'(rx), 32'hFFFF_FFFF);
                            end else begin
                                chk("rx_byte", 32'(rx), 32'(exp_b.pop_front()));
                            end
                        end
                    end
                    if (cnt == NB * C - 1) begin
                        in_frame = 0;
                        if (nbytes % 4 == 3) begin
                            if (exp_l.size() == 0 || exp_e.size() == 0) begin
                                chk("unexpected_word", 32'd1, 32'd0);
                            end else begin
                                pend   = 1;
                                pend_v = exp_l.pop_front();
                                pend_e = exp_e.pop_front();
                            end
                        end
                        nbytes++;
                    end
                end else if (txd == 1'b0) begin
                    in_frame = 1;
                    cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit l,
                        output int stamp, output int waits);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        waits  = 0;
        stamp  = -1;
        while (!tready && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        if (!tready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            tvalid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            stamp = cyc;
            for (int i = 0; i < 4; i++) exp_b.push_back(d[i*8 +: 8]);
            exp_l.push_back(l);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pend || in_frame || exp_b.size() != 0 ||
                exp_e.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, w, bc, lc;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_done", 32'(ld), 32'd0);
        chk("rst_tready", 32'(tready), 32'd0);
        reset_n = 1'b1;
        chk("tready_before_edge", 32'(tready), 32'd0);
        @(negedge clk);
        chk("tready_after_release", 32'(tready), 32'd1);

        send(32'h4433_2211, 1'b0, a1, w);
        tvalid = 1'b0;
        exp_e.push_back(a1 + 1 + WC);
        bc = busy ? 1 : 0;
        for (int i = 0; i < WC; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("busy_throughout", bc, WC + 1);
        @(negedge clk);
        chk("busy_after_word", 32'(busy), 32'd0);
        wait_idle();

        send(32'h8877_6655, 1'b0, a1, w);
        exp_e.push_back(a1 + 1 + WC);
        send(32'hCCBB_AA99, 1'b1, a2, w);
        tvalid = 1'b0;
        chk("b2b_accept2", a2, a1 + 2);
        exp_e.push_back(a1 + 1 + 2 * WC);
        wait_idle();

        send(32'hA5A5_A5A5, 1'b1, a1, w);
        tvalid = 1'b0;
        exp_e.push_back(a1 + 1 + WC);
        wait_idle();

        send(32'h0102_0304, 1'b0, a1, w);
        exp_e.push_back(a1 + 1 + WC);
        send(32'hF0E1_D2C3, 1'b0, a2, w);
        exp_e.push_back(a1 + 1 + 2 * WC);
        send(32'h5A69_7887, 1'b1, a3, w);
        tvalid = 1'b0;
        chk("full_accept2", a2, a1 + 2);
        chk("full_accept3", a3, a1 + 2 + WC);
        chk("full_wait3", w, WC - 1);
        exp_e.push_back(a1 + 1 + 3 * WC);
        wait_idle();

        send(32'h0BAD_F00D, 1'b1, a1, w);
        tvalid = 1'b0;
        exp_e.push_back(a1 + 1 + WC);
        repeat (2 * NB * C + 2 * C) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_txd", 32'(txd), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tready", 32'(tready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_tready_release", 32'(tready), 32'd0);
        @(negedge clk);
        chk("abort_tready_up", 32'(tready), 32'd1);
        lc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ld) lc++;
        end
        chk("abort_no_last_done", lc, 0);
        chk("abort_line_idle", 32'(txd), 32'd1);

        send(32'h0000_0007, 1'b1, a1, w);
        tvalid = 1'b0;
        exp_e.push_back(a1 + 1 + WC);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
